// File: rtl/modmul_pkg.sv
// Shared types for the sequential modular multiplier: controller states and idx sizing.
package modmul_pkg;

    typedef enum logic [1:0] {IDLE, DBL, ADD, DONE} state_t;

    // Bit index counter width; a one-bit operand still needs a one-bit index.
    function automatic int idx_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    localparam int IDX_W_DEFAULT = idx_width(8);

endpackage

// File: rtl/moduloadd.sv
// Combinational (x + y) mod MODULUS for x, y < MODULUS: one add, one trial subtract, select.
module moduloadd #(
    parameter int                 MOD_LEN = 8,
    parameter logic [MOD_LEN-1:0] MODULUS = 8'd251
) (
    input  logic [MOD_LEN-1:0] op_a,
    input  logic [MOD_LEN-1:0] op_b,
    output logic [MOD_LEN-1:0] sum
);

    localparam int W = MOD_LEN + 2;

    logic [W-1:0] raw;
    logic [W-1:0] trial;

    // Extra top bit makes the trial subtract's sign bit a clean "raw < MODULUS" flag.
    assign raw   = {2'b00, op_a} + {2'b00, op_b};
    assign trial = raw - {2'b00, MODULUS};
    assign sum   = trial[W-1] ? raw[MOD_LEN-1:0] : trial[MOD_LEN-1:0];

endmodule

// File: rtl/modmul_seq.sv
// MSB-first double-and-add modular multiplier sharing one moduloadd between the
// double and add steps; start/busy/valid handshake, one operation in flight.
module modmul_seq
    import modmul_pkg::*;
#(
    parameter int                 MOD_LEN = 8,
    parameter logic [MOD_LEN-1:0] MODULUS = 8'd251
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MOD_LEN-1:0] a_in,
    input  logic [MOD_LEN-1:0] b_in,
    output logic               busy,
    output logic               valid,
    output logic [MOD_LEN-1:0] result
);

    localparam int IDX_W = idx_width(MOD_LEN);

    state_t             state;
    logic [MOD_LEN-1:0] a_reg;
    logic [MOD_LEN-1:0] b_reg;
    logic [MOD_LEN-1:0] acc;
    logic [IDX_W-1:0]   idx;
    logic [MOD_LEN-1:0] add_b;
    logic [MOD_LEN-1:0] add_sum;

    // Doubling is acc+acc, so only the second operand needs steering.
    assign add_b = (state == ADD) ? a_reg : acc;

    moduloadd #(
        .MOD_LEN (MOD_LEN),
        .MODULUS (MODULUS)
    ) u_add (
        .op_a (acc),
        .op_b (add_b),
        .sum  (add_sum)
    );

    assign result = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        acc   <= '0;
                        idx   <= IDX_W'(MOD_LEN - 1);
                        busy  <= 1'b1;
                        state <= DBL;
                    end
                end
                DBL: begin
                    acc <= add_sum;
                    // A set bit defers the idx step to ADD so both steps see the same bit.
                    if (b_reg[idx]) begin
                        state <= ADD;
                    end else if (idx == '0) begin
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ADD: begin
                    acc <= add_sum;
                    if (idx == '0) begin
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= DBL;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modmul_seq.sv
// Bench for modmul_seq: directed vectors, back-to-back starts, mid-op reset and
// randomized ops against (a*b)%M with latency 1+MOD_LEN+popcount(b).
module tb_modmul_seq;

    localparam int          MOD_LEN = 8;
    localparam logic [7:0]  MODULUS = 8'd251;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       valid;
    logic [7:0] result;

    int checks   = 0;
    int failures = 0;

    modmul_seq #(.MOD_LEN(MOD_LEN), .MODULUS(MODULUS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .valid  (valid),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        return 8'((int'(a) * int'(b)) % int'(MODULUS));
    endfunction

    function automatic int ref_lat(input logic [7:0] b);
        return 1 + MOD_LEN + $countones(b);
    endfunction

    // Drives one operation and reports what it saw; comparisons are left to the caller.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output int lat,
                         output logic busy_after_accept, output bit timed_out);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        busy_after_accept = busy;
        timed_out = 1'b1;
        lat = 0;
        res = 'x;
        for (int k = 0; k < 40; k++) begin
            if (valid) begin
                lat = k + 1;
                res = result;
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, valid, result} !== 10'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b valid=%b result=%0d expected 0/0/0", busy, valid, result);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] av [4] = '{8'd3, 8'd250, 8'd200, 8'd0};
        logic [7:0] bv [4] = '{8'd5, 8'd250, 8'd0,   8'd250};
        logic [7:0] res;
        int         lat;
        logic       bz;
        bit         to;
        for (int i = 0; i < 4; i++) begin
            do_op(av[i], bv[i], res, lat, bz, to);
            checks++;
            if (to) begin
                failures++;
                $display("FAIL directed_timeout a=%0d b=%0d no valid within 40 cycles", av[i], bv[i]);
                continue;
            end
            if (res !== ref_mul(av[i], bv[i])) begin
                failures++;
                $display("FAIL directed_result a=%0d b=%0d got %0d expected %0d", av[i], bv[i], res, ref_mul(av[i], bv[i]));
            end
            checks++;
            if (lat != ref_lat(bv[i])) begin
                failures++;
                $display("FAIL directed_latency a=%0d b=%0d got %0d expected %0d", av[i], bv[i], lat, ref_lat(bv[i]));
            end
            checks++;
            if (bz !== 1'b1) begin
                failures++;
                $display("FAIL directed_busy_rise got %b expected 1", bz);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({busy, valid} !== 2'b00 || result !== ref_mul(av[i], bv[i])) begin
                failures++;
                $display("FAIL directed_after_done busy=%b valid=%b result=%0d expected 0/0/%0d",
                         busy, valid, result, ref_mul(av[i], bv[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int last_v = -1;
        int nvalid = 0;
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd7;
        b_in  = 8'd9;
        for (int cyc = 0; cyc < 62; cyc++) begin
            @(negedge clk);
            if (valid) begin
                nvalid++;
                checks++;
                if (result !== 8'd63) begin
                    failures++;
                    $display("FAIL b2b_result got %0d expected 63", result);
                end
                if (last_v >= 0) begin
                    checks++;
                    if (cyc - last_v != 12) begin
                        failures++;
                        $display("FAIL b2b_period got %0d expected 12", cyc - last_v);
                    end
                end
                last_v = cyc;
            end
            // Garbage while busy must not leak into the next accepted operation.
            if (busy) begin
                a_in = 8'($urandom);
                b_in = 8'($urandom);
            end else begin
                a_in = 8'd7;
                b_in = 8'd9;
            end
        end
        start = 1'b0;
        checks++;
        if (nvalid < 4) begin
            failures++;
            $display("FAIL b2b_count got %0d expected at least 4", nvalid);
        end
        repeat (15) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [7:0] res;
        int         lat;
        logic       bz;
        bit         to;
        bit         stray = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a_in  = 8'd100;
        b_in  = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, valid, result} !== 10'd0) begin
            failures++;
            $display("FAIL midreset_state busy=%b valid=%b result=%0d expected 0/0/0", busy, valid, result);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (valid || busy) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            failures++;
            $display("FAIL midreset_stray got activity=1 expected 0");
        end
        do_op(8'd10, 8'd20, res, lat, bz, to);
        checks++;
        if (to || res !== 8'd200 || lat != ref_lat(8'd20)) begin
            failures++;
            $display("FAIL midreset_next_op timeout=%0d result=%0d lat=%0d expected 0/200/%0d",
                     to, res, lat, ref_lat(8'd20));
        end
        @(posedge clk);
    endtask

    task automatic test_random();
        logic [7:0] a, b, res;
        int         lat;
        logic       bz;
        bit         to;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(250, 0));
            b = 8'($urandom_range(250, 0));
            do_op(a, b, res, lat, bz, to);
            checks++;
            if (to || res !== ref_mul(a, b) || lat != ref_lat(b) || bz !== 1'b1) begin
                failures++;
                $display("FAIL random_op a=%0d b=%0d timeout=%0d result=%0d expected %0d lat=%0d expected %0d busy=%b",
                         a, b, to, res, ref_mul(a, b), lat, ref_lat(b), bz);
            end
            @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
